// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard control: load-use stall, branch squash, LM/SM sequencing.
// Drives IF/ID freeze/flush, PC write-enable and the ID/EX bubble.
module if_id_hazard_ctrl #(
  parameter int         WORD_LEN = 16,
  parameter int         MASK_W   = 8,
  parameter logic [3:0] OPC_LM   = 4'b0110,
  parameter logic [3:0] OPC_SM   = 4'b0111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [2:0]        id_rs1,
  input  logic [2:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [MASK_W-1:0] id_mask,
  input  logic              ex_is_load,
  input  logic [2:0]        ex_rd,
  input  logic              br_taken,
  output logic              freeze,
  output logic              flush,
  output logic              pc_write_en,
  output logic              idex_bubble,
  output logic              lmsm_active,
  output logic [2:0]        lmsm_reg,
  output logic              lmsm_first
);

  typedef enum logic [1:0] {
    RUN,
    LDUSE,
    MULTI
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [MASK_W-1:0] rem;
  logic [MASK_W-1:0] rem_n;
  logic [MASK_W-1:0] rem_rest;
  logic              first;
  logic              first_n;
  logic              hazard;
  logic              lm_go;
  logic [2:0]        lo_idx;

  // Detect a load-use hazard and a multi-cycle LM/SM request in ID.
  always_comb begin
    hazard = id_valid & ex_is_load &
             ((id_uses_rs1 & (id_rs1 == ex_rd)) |
              (id_uses_rs2 & (id_rs2 == ex_rd)));
    lm_go  = id_valid &
             ((id_opcode == OPC_LM) | (id_opcode == OPC_SM)) &
             (id_mask != '0);
  end

  // Locate the lowest pending register and the mask without it.
  always_comb begin
    lo_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (rem[i]) lo_idx = i[2:0];
    end
    rem_rest = rem & (rem - 1'b1);
  end

  // Prioritised control: branch, load-use, LM/SM entry, sequencing.
  always_comb begin
    freeze      = 1'b0;
    flush       = 1'b0;
    pc_write_en = 1'b1;
    idex_bubble = 1'b0;
    lmsm_active = 1'b0;
    lmsm_reg    = '0;
    lmsm_first  = 1'b0;
    state_n     = state;
    rem_n       = rem;
    first_n     = 1'b0;

    if (state == MULTI) begin
      lmsm_active = 1'b1;
      lmsm_reg    = lo_idx;
      lmsm_first  = first;
    end

    if (br_taken) begin
      flush       = 1'b1;
      idex_bubble = 1'b1;
      state_n     = RUN;
      rem_n       = '0;
    end else if ((state == RUN) && hazard) begin
      freeze      = 1'b1;
      pc_write_en = 1'b0;
      idex_bubble = 1'b1;
      state_n     = LDUSE;
    end else if ((state != MULTI) && lm_go) begin
      freeze      = 1'b1;
      pc_write_en = 1'b0;
      idex_bubble = 1'b1;
      state_n     = MULTI;
      rem_n       = id_mask;
      first_n     = 1'b1;
    end else if (state == MULTI) begin
      rem_n = rem_rest;
      if (rem_rest != '0) begin
        freeze      = 1'b1;
        pc_write_en = 1'b0;
      end else begin
        state_n = RUN;
      end
    end else begin
      state_n = RUN;
    end

    // Reset forces quiet outputs regardless of what ID presents.
    if (!rst) begin
      freeze      = 1'b0;
      flush       = 1'b0;
      pc_write_en = 1'b1;
      idex_bubble = 1'b0;
      lmsm_active = 1'b0;
      lmsm_reg    = '0;
      lmsm_first  = 1'b0;
    end
  end

  // State, remaining mask and first-micro-op flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      rem   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      first <= first_n;
    end
  end

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Randomised bench for if_id_hazard_ctrl against a queue-based model.
// Directed scenarios first, then random traffic with occasional resets.
module tb_if_id_hazard_ctrl;

  localparam logic [3:0] LM = 4'b0110;
  localparam logic [3:0] SM = 4'b0111;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [7:0] id_mask;
  logic       ex_is_load;
  logic [2:0] ex_rd;
  logic       br_taken;
  logic       freeze;
  logic       flush;
  logic       pc_write_en;
  logic       idex_bubble;
  logic       lmsm_active;
  logic [2:0] lmsm_reg;
  logic       lmsm_first;

  int n_vec = 0;
  int n_bad = 0;

  // model: mode 0=normal, 1=just stalled on load, 2=sequencing
  int mode = 0;
  int regs[$];
  bit first_m = 0;

  if_id_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_mask(id_mask), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .br_taken(br_taken),
    .freeze(freeze), .flush(flush),
    .pc_write_en(pc_write_en), .idex_bubble(idex_bubble),
    .lmsm_active(lmsm_active), .lmsm_reg(lmsm_reg),
    .lmsm_first(lmsm_first)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [3:0] op,
                     input logic [2:0] s1, input logic [2:0] s2,
                     input bit u1, input bit u2, input logic [7:0] m,
                     input bit ld, input logic [2:0] rd, input bit br);
    bit e_fr, e_fl, e_pc, e_bub, e_act, e_first;
    int e_reg;
    bit hz, go;
    @(negedge clk);
    rst = r; id_valid = v; id_opcode = op;
    id_rs1 = s1; id_rs2 = s2;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_mask = m; ex_is_load = ld; ex_rd = rd; br_taken = br;
    #1;
    e_fr = 0; e_fl = 0; e_pc = 1; e_bub = 0;
    e_act = 0; e_reg = 0; e_first = 0;
    if (!r) begin
      mode = 0; regs = {}; first_m = 0;
    end else begin
      hz = v && ld && ((u1 && s1 == rd) || (u2 && s2 == rd));
      go = v && (op == LM || op == SM) && m != 0;
      if (mode == 2) begin
        e_act = 1; e_reg = regs[0]; e_first = first_m;
      end
      if (br) begin
        e_fl = 1; e_bub = 1; mode = 0; regs = {}; first_m = 0;
      end else if (mode == 0 && hz) begin
        e_fr = 1; e_pc = 0; e_bub = 1; mode = 1; first_m = 0;
      end else if (mode != 2 && go) begin
        e_fr = 1; e_pc = 0; e_bub = 1;
        regs = {};
        for (int i = 0; i < 8; i++) if (m[i]) regs.push_back(i);
        mode = 2; first_m = 1;
      end else if (mode == 2) begin
        if (regs.size() > 1) begin e_fr = 1; e_pc = 0; end
        void'(regs.pop_front());
        mode = (regs.size() > 0) ? 2 : 0;
        first_m = 0;
      end else begin
        mode = 0; first_m = 0;
      end
    end
    check("freeze", 8'(freeze), 8'(e_fr));
    check("flush", 8'(flush), 8'(e_fl));
    check("pc_we", 8'(pc_write_en), 8'(e_pc));
    check("bubble", 8'(idex_bubble), 8'(e_bub));
    check("active", 8'(lmsm_active), 8'(e_act));
    check("reg", 8'(lmsm_reg), 8'(e_reg));
    check("first", 8'(lmsm_first), 8'(e_first));
  endtask

  task automatic idle(input bit r);
    cyc(r, 0, 4'h0, 3'd0, 3'd0, 0, 0, 8'h00, 0, 3'd0, 0);
  endtask

  task automatic lm(input logic [3:0] op, input logic [7:0] m);
    cyc(1, 1, op, 3'd0, 3'd0, 0, 0, m, 0, 3'd0, 0);
  endtask

  task automatic branch();
    cyc(1, 0, 4'h0, 3'd0, 3'd0, 0, 0, 8'h00, 0, 3'd0, 1);
  endtask

  initial begin
    rst = 1'b0;
    idle(0); idle(0); idle(1);
    // load-use: one stall, then the held instr passes
    cyc(1, 1, 4'h1, 3'd3, 3'd0, 1, 0, 8'h00, 1, 3'd3, 0);
    cyc(1, 1, 4'h1, 3'd3, 3'd0, 1, 0, 8'h00, 1, 3'd3, 0);
    idle(1);
    // branch squash, then quiet
    branch(); idle(1);
    // LM 0x25 -> regs 0,2,5
    lm(LM, 8'h25); idle(1); idle(1); idle(1); idle(1);
    // SM 0x80 -> reg 7; LM with empty mask
    lm(SM, 8'h80); idle(1); idle(1);
    lm(LM, 8'h00); idle(1);
    // branch in 2nd micro-op of 0xFF
    lm(LM, 8'hFF); idle(1); branch(); idle(1); idle(1);
    // reset in 2nd micro-op of 0xFF
    lm(LM, 8'hFF); idle(1); idle(0); idle(0); idle(1); idle(1);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] op;
      logic [7:0] m;
      int sel;
      sel = $urandom_range(0, 3);
      op = (sel == 0) ? LM : (sel == 1) ? SM : 4'($urandom);
      sel = $urandom_range(0, 3);
      m = (sel == 0) ? 8'h00 :
          (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      cyc(($urandom % 100) != 0, ($urandom % 5) != 0, op,
          3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), m,
          ($urandom % 5) < 2, 3'($urandom_range(0, 3)),
          ($urandom % 12) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
